// File: rtl/serial_adder_nbit_if.sv
// Operand/result bundle for serial_adder_nbit; ovf exists only when SERIAL_ADD_OVF_EN is defined.
// master drives the request side, slave is the adder.
interface serial_adder_nbit_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_ADD_OVF_EN
    modport master (output start, A, B, Cin, input busy, done, S, Cout, ovf);
    modport slave  (input start, A, B, Cin, output busy, done, S, Cout, ovf);
`else
    modport master (output start, A, B, Cin, input busy, done, S, Cout);
    modport slave  (input start, A, B, Cin, output busy, done, S, Cout);
`endif
endinterface

// File: rtl/serial_adder_nbit.sv
// Bit-serial adder: one full-adder cell resolves one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_nbit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_nbit_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               sum_bit;
    logic               maj;
    logic               last_bit;
    logic [WIDTH-1:0]   res_shift;

    always_comb begin
        sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
        maj       = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last_bit  = (cnt_q == CntW'(WIDTH - 1));
        // Shift-then-insert keeps this legal for WIDTH=1, where no upper slice exists.
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = sum_bit;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = bus.Cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                res_d   = res_shift;
                carry_d = maj;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
                    state_d = StIdle;
                    s_d     = res_shift;
                    cout_d  = maj;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q here is the carry into the MSB cell.
                    ovf_d   = carry_q ^ maj;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule
